// File: rtl/note_track_engine.sv
`default_nettype none
// ============================================================================
// Module   : note_track_engine
// Purpose  : Rhythm-game note engine. Plays a chart one row per spawn_tick,
//            allocates falling note squares into per-lane slot pools, moves
//            them down on every frame_tick and reports per-lane pixel hits
//            for the video mixer.
// Ports    : clk, reset (async, active high)
//            start       - begin playback (honoured in IDLE only)
//            frame_tick  - move all active notes by SPEED pixels
//            spawn_tick  - fetch the next chart row (honoured in SPAWN only)
//            chart_addr  - chart memory address; chart_data valid 1 cycle later
//            chart_data  - one bit per lane, 1 = spawn a note
//            x, y        - current pixel; lane_hit is registered from them
//            lane_hit    - per-lane "pixel inside an active note"
//            busy        - high in SPAWN, FETCH and DRAIN
//            overflow    - sticky: a note was dropped for lack of a free slot
//            miss_count  - notes that left the bottom of the screen
// Options  : NOTE_MISS_COUNT_EN - enables the saturating miss counter;
//            without it miss_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module note_track_engine #(
  parameter int SLOTS       = 4,
  parameter int CHART_DEPTH = 64,
  parameter int NOTE_W      = 50,
  parameter int SPEED       = 2,
  parameter int LANE_X0     = 170,
  parameter int LANE_PITCH  = 100,
  localparam int CHART_AW   = $clog2(CHART_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                frame_tick,
  input  logic                spawn_tick,
  output logic [CHART_AW-1:0] chart_addr,
  input  logic [3:0]          chart_data,
  input  logic [9:0]          x,
  input  logic [8:0]          y,
  output logic [3:0]          lane_hit,
  output logic                busy,
  output logic                overflow,
  output logic [7:0]          miss_count
);

  localparam int LANES = 4;
  localparam logic signed [10:0] SPAWN_POS = 11'(-NOTE_W);
  localparam logic signed [10:0] STEP      = 11'(SPEED);
  localparam logic signed [10:0] BOTTOM    = 11'sd480;
  localparam logic signed [11:0] NOTE_W_S  = 12'(NOTE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SLOTS-1:0]   active [LANES];
  logic signed [10:0] pos    [LANES][SLOTS];
  logic signed [10:0] moved  [LANES][SLOTS];
  logic [SLOTS-1:0]   alloc  [LANES];
  logic [SLOTS-1:0]   freed  [LANES];
  logic [LANES-1:0]   drop;
  logic [LANES-1:0]   hit_next;
  logic               any_active;
  logic               accept_start;
  logic               last_entry;

  assign accept_start = (state == IDLE) && start;
  assign last_entry   = (chart_addr == CHART_AW'(CHART_DEPTH - 1));
  assign busy         = (state != IDLE);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SPAWN;
      SPAWN:   if (spawn_tick) state_next = FETCH;
      FETCH:   state_next = last_entry ? DRAIN : SPAWN;
      DRAIN:   if (!any_active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address is held on the final row so it never points past the chart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                chart_addr <= '0;
    else if (accept_start)                    chart_addr <= '0;
    else if (state == FETCH && !last_entry)   chart_addr <= chart_addr + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (accept_start) overflow <= 1'b0;
    else if (|drop)        overflow <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Slot bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    any_active = 1'b0;
    for (int k = 0; k < LANES; k++) any_active = any_active | (|active[k]);
  end

  // Lowest-index free slot per requesting lane; a lane with no free slot drops.
  always_comb begin : p_alloc
    logic found;
    drop = '0;
    for (int k = 0; k < LANES; k++) begin
      alloc[k] = '0;
      found    = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (!active[k][s] && !found) begin
          alloc[k][s] = (state == FETCH) && chart_data[k];
          found       = 1'b1;
        end
      end
      drop[k] = (state == FETCH) && chart_data[k] && !found;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      for (int s = 0; s < SLOTS; s++) begin
        moved[k][s] = pos[k][s] + STEP;
        freed[k][s] = active[k][s] && frame_tick && (moved[k][s] >= BOTTOM);
      end
    end
  end

  // A slot is either moving (already active) or being allocated, never both,
  // so a freshly spawned note ignores a coincident frame_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) begin
        active[k] <= '0;
        for (int s = 0; s < SLOTS; s++) pos[k][s] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (active[k][s]) begin
            if (frame_tick) begin
              pos[k][s] <= moved[k][s];
              if (freed[k][s]) active[k][s] <= 1'b0;
            end
          end else if (alloc[k][s]) begin
            active[k][s] <= 1'b1;
            pos[k][s]    <= SPAWN_POS;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel hit test; y is widened to signed so notes above the screen
  // (negative position) clip naturally.
  // --------------------------------------------------------------------------
  always_comb begin : p_hit
    logic [11:0]        x_ext;
    logic signed [11:0] y_s;
    logic [11:0]        lx;
    logic               in_x;
    logic signed [11:0] top;
    x_ext    = {2'b00, x};
    y_s      = signed'({3'b000, y});
    hit_next = '0;
    for (int k = 0; k < LANES; k++) begin
      lx   = 12'(LANE_X0 + k * LANE_PITCH);
      in_x = (x_ext >= lx) && (x_ext < lx + 12'(NOTE_W));
      for (int s = 0; s < SLOTS; s++) begin
        top = {pos[k][s][10], pos[k][s]};
        if (active[k][s] && in_x && (y_s >= top) && (y_s < top + NOTE_W_S))
          hit_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lane_hit <= '0;
    else       lane_hit <= hit_next;
  end

  // --------------------------------------------------------------------------
  // Miss counter
  // --------------------------------------------------------------------------
`ifdef NOTE_MISS_COUNT_EN
  logic [8:0] n_freed;
  logic [8:0] miss_sum;
  logic [7:0] miss_r;

  always_comb begin
    n_freed = '0;
    for (int k = 0; k < LANES; k++)
      for (int s = 0; s < SLOTS; s++)
        n_freed = n_freed + 9'(freed[k][s]);
    miss_sum = {1'b0, miss_r} + n_freed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 miss_r <= '0;
    else if (accept_start)     miss_r <= '0;
    else if (miss_sum > 9'd255) miss_r <= 8'd255;
    else                       miss_r <= miss_sum[7:0];
  end

  assign miss_count = miss_r;
`else
  assign miss_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_note_track_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_track_engine
// Purpose  : Self-checking bench for note_track_engine. A default-size
//            instance runs a table of spawn / frame / probe operations; a
//            CHART_DEPTH=2 instance covers drain, restart and reset-in-drain.
// Options  : NOTE_MISS_COUNT_EN selects the expected miss_count values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_track_engine;

`ifdef NOTE_MISS_COUNT_EN
  localparam int MISS_ON = 1;
`else
  localparam int MISS_ON = 0;
`endif

  localparam int OP_SPAWN = 0;
  localparam int OP_FRAME = 1;
  localparam int OP_PROBE = 2;

  typedef struct {
    int         op;
    logic [3:0] data;   // chart row for OP_SPAWN
    int         n;      // frame count, or frame-with-fetch flag for OP_SPAWN
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] hit;    // expected lane_hit for OP_PROBE
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic       reset, start, frame_tick, spawn_tick;
  logic [5:0] chart_addr;
  logic [3:0] chart_data;
  logic [9:0] x;
  logic [8:0] y;
  logic [3:0] lane_hit;
  logic       busy, overflow;
  logic [7:0] miss_count;

  note_track_engine dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .spawn_tick(spawn_tick), .chart_addr(chart_addr), .chart_data(chart_data),
    .x(x), .y(y), .lane_hit(lane_hit), .busy(busy), .overflow(overflow),
    .miss_count(miss_count)
  );

  // Instance 2: two-entry chart
  logic       reset2, start2, frame2, spawn2;
  logic [0:0] chart_addr2;
  logic [3:0] data2;
  logic [9:0] x2;
  logic [8:0] y2;
  logic [3:0] lane_hit2;
  logic       busy2, overflow2;
  logic [7:0] miss2;

  note_track_engine #(.CHART_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .frame_tick(frame2),
    .spawn_tick(spawn2), .chart_addr(chart_addr2), .chart_data(data2),
    .x(x2), .y(y2), .lane_hit(lane_hit2), .busy(busy2), .overflow(overflow2),
    .miss_count(miss2)
  );

  int   applied    = 0;
  int   miscompares = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_spawn(input logic [3:0] d, input int with_frame);
    tbl.push_back('{op: OP_SPAWN, data: d, n: with_frame, x: '0, y: '0, hit: '0});
  endtask
  task automatic add_frame(input int n);
    tbl.push_back('{op: OP_FRAME, data: '0, n: n, x: '0, y: '0, hit: '0});
  endtask
  task automatic add_probe(input int px, input int py, input logic [3:0] h);
    tbl.push_back('{op: OP_PROBE, data: '0, n: 0, x: 10'(px), y: 9'(py), hit: h});
  endtask

  // Instance 1 operations (engine must be in SPAWN for do_spawn)
  task automatic do_spawn(input logic [3:0] d, input int with_frame);
    chart_data = d; spawn_tick = 1'b1;
    tick();
    spawn_tick = 1'b0; frame_tick = (with_frame != 0);
    tick();
    frame_tick = 1'b0; chart_data = 4'b0000;
  endtask
  task automatic do_frame(input int n);
    frame_tick = 1'b1;
    repeat (n) tick();
    frame_tick = 1'b0;
  endtask

  // Instance 2 operations
  task automatic do_spawn2(input logic [3:0] d);
    data2 = d; spawn2 = 1'b1;
    tick();
    spawn2 = 1'b0;
    tick();
    data2 = 4'b0000;
  endtask
  task automatic do_frame2(input int n);
    frame2 = 1'b1;
    repeat (n) tick();
    frame2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; spawn_tick = 1'b0;
    chart_data = 4'b0; x = '0; y = '0;
    reset2 = 1'b1; start2 = 1'b0; frame2 = 1'b0; spawn2 = 1'b0;
    data2 = 4'b0; x2 = '0; y2 = '0;

    // ---- Table: lane0 note walk, coincident fetch/frame, all lanes, exit ----
    add_spawn(4'b0001, 0);            // L0s0 at -50
    add_frame(10);                    // -30: rows 0..19 visible
    add_probe(170, 0,  4'b0001);
    add_probe(170, 19, 4'b0001);
    add_probe(170, 20, 4'b0000);
    add_frame(15);                    // 0
    add_probe(170, 0,  4'b0001);
    add_probe(219, 49, 4'b0001);
    add_probe(220, 0,  4'b0000);
    add_probe(169, 0,  4'b0000);
    add_probe(170, 50, 4'b0000);
    add_probe(195, 25, 4'b0001);
    add_probe(270, 0,  4'b0000);
    add_spawn(4'b0011, 1);            // old -> 2; L0s1, L1s0 at -50
    add_probe(170, 1,  4'b0000);
    add_probe(170, 2,  4'b0001);
    add_probe(170, 51, 4'b0001);
    add_probe(170, 52, 4'b0000);
    add_probe(270, 0,  4'b0000);
    add_frame(26);                    // old 54, new 2
    add_probe(270, 2,  4'b0010);
    add_probe(270, 1,  4'b0000);
    add_probe(170, 51, 4'b0001);
    add_probe(170, 53, 4'b0000);
    add_probe(170, 54, 4'b0001);
    add_probe(170, 103, 4'b0001);
    add_probe(170, 104, 4'b0000);
    add_probe(300, 10, 4'b0010);
    add_probe(320, 10, 4'b0000);
    add_spawn(4'b1100, 0);            // L2, L3 at -50
    add_frame(25);                    // L0s0 104, L0s1/L1 52, L2/L3 0
    add_probe(370, 0,  4'b0100);
    add_probe(470, 49, 4'b1000);
    add_probe(519, 0,  4'b1000);
    add_probe(520, 0,  4'b0000);
    add_probe(170, 0,  4'b0000);
    add_probe(170, 52, 4'b0001);
    add_frame(187);                   // L0s0 478, L0s1 426
    add_probe(170, 478, 4'b0001);
    add_probe(170, 477, 4'b0000);
    add_frame(1);                     // L0s0 freed, L0s1 428
    add_probe(170, 478, 4'b0000);
    add_probe(170, 477, 4'b0001);
    add_probe(170, 430, 4'b0001);

    tick(); tick();
    reset = 1'b0; reset2 = 1'b0;
    tick();

    // ---- Reset state ----
    chk("reset_busy",       busy,       0);
    chk("reset_overflow",   overflow,   0);
    chk("reset_chart_addr", chart_addr, 0);
    chk("reset_lane_hit",   lane_hit,   0);
    chk("reset_miss",       miss_count, 0);
    chk("reset_busy2",      busy2,      0);

    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_SPAWN: do_spawn(tbl[i].data, tbl[i].n);
        OP_FRAME: do_frame(tbl[i].n);
        default: begin
          x = tbl[i].x; y = tbl[i].y;
          tick();
          chk($sformatf("probe%0d_x%0d_y%0d", i, tbl[i].x, tbl[i].y),
              lane_hit, tbl[i].hit);
        end
      endcase
    end
    chk("table_chart_addr", chart_addr, 3);
    chk("table_miss",       miss_count, MISS_ON);
    chk("table_overflow",   overflow,   0);

    // ---- Asynchronous reset mid-playback ----
    reset = 1'b1; #1;
    chk("async_reset_busy",     busy,     0);
    chk("async_reset_lane_hit", lane_hit, 0);
    tick(); reset = 1'b0; tick();

    // ---- Slot exhaustion in lane 3 ----
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) do_spawn(4'b1000, 0);
    chk("four_spawn_overflow", overflow, 0);
    do_spawn(4'b1000, 0);
    chk("fifth_spawn_overflow", overflow, 1);
    start = 1'b1; tick(); start = 1'b0;   // not IDLE: ignored
    chk("ignored_start_overflow", overflow,   1);
    chk("ignored_start_addr",     chart_addr, 5);
    x = 470; y = 0;
    do_frame(25);
    tick();
    chk("lane3_hit", lane_hit, 4'b1000);

    // ---- Two-entry chart: drain until last note exits ----
    start2 = 1'b1; tick(); start2 = 1'b0;
    do_spawn2(4'b0001);
    chk("d2_addr_after_first", chart_addr2, 1);
    do_spawn2(4'b0010);
    chk("d2_drain_busy", busy2, 1);
    do_frame2(264);                   // both at 478
    chk("d2_busy_at_478", busy2, 1);
    do_frame2(1);                     // both freed together
    tick();
    chk("d2_idle_after_exit", busy2, 0);
    chk("d2_miss_two",        miss2, 2 * MISS_ON);
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("d2_restart_busy", busy2, 1);
    chk("d2_restart_miss", miss2, 0);

    // ---- Reset while draining three notes ----
    do_spawn2(4'b0111);
    do_spawn2(4'b0000);
    do_frame2(25);
    x2 = 170; y2 = 0;
    tick();
    chk("d2_hit_before_reset", lane_hit2, 4'b0001);
    reset2 = 1'b1; #1;
    chk("d2_reset_busy",     busy2,     0);
    chk("d2_reset_lane_hit", lane_hit2, 0);
    tick(); reset2 = 1'b0; tick();
    chk("d2_post_reset_busy", busy2,     0);
    chk("d2_post_reset_hit",  lane_hit2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_track_engine.md
NOTE_TRACK_ENGINE -- requirements
Module: note_track_engine

Interface
REQ-001 Parameter SLOTS, default 4: note slots per lane.
REQ-002 Parameter CHART_DEPTH, default 64: chart entries; CHART_AW = clog2(CHART_DEPTH).
REQ-003 Parameter NOTE_W, default 50: note square side in pixels.
REQ-004 Parameter SPEED, default 2: pixels moved per frame tick.
REQ-005 Parameter LANE_X0, default 170, and parameter LANE_PITCH, default 100: lane k left edge = LANE_X0 + k*LANE_PITCH.
REQ-006 clk  in  1  system clock, 100 MHz.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins chart playback.
REQ-009 frame_tick  in  1  one-cycle pulse, once per displayed frame.
REQ-010 spawn_tick  in  1  one-cycle pulse, once per chart step.
REQ-011 chart_addr  out  CHART_AW  chart memory read address.
REQ-012 chart_data  in  4  chart row; bit k set means a note in lane k; valid one cycle after chart_addr.
REQ-013 x  in  10  current pixel column.
REQ-014 y  in  9  current pixel row.
REQ-015 lane_hit  out  4  bit k high when pixel (x,y) lies inside any active note of lane k.
REQ-016 busy  out  1  high in states SPAWN, FETCH and DRAIN.
REQ-017 overflow  out  1  sticky flag: a note was dropped because its lane had no free slot.
REQ-018 miss_count  out  8  count of notes that left the screen bottom.

Function
REQ-019 FSM states: IDLE, SPAWN, FETCH, DRAIN.
REQ-020 FSM transitions: IDLE->SPAWN on start; SPAWN->FETCH on spawn_tick; FETCH->SPAWN after one cycle while chart_addr < CHART_DEPTH-1; FETCH->DRAIN after the last entry; DRAIN->IDLE when no slot is active.
REQ-021 start outside IDLE is ignored.
REQ-022 chart_addr resets to 0 on start and increments on exit from FETCH.
REQ-023 In FETCH, for each lane k with chart_data[k]=1, the lowest-index free slot becomes active with position -NOTE_W.
REQ-024 If lane k has no free slot, the note is dropped and overflow is set.
REQ-025 Slot position is signed 11-bit.
REQ-026 On frame_tick, every active slot adds SPEED to its position.
REQ-027 A slot that is allocated in the same cycle as frame_tick is not moved in that cycle.
REQ-028 A slot whose updated position is >= 480 becomes free in the same update.
REQ-029 lane_hit[k] is registered with 1-cycle latency from x/y.
REQ-030 lane_hit[k] = OR over active slots s of (LANE_Xk <= x < LANE_Xk+NOTE_W) AND (pos_s <= y < pos_s+NOTE_W), comparisons signed; a partly off-screen note draws only its visible rows.
REQ-031 spawn_tick outside SPAWN is ignored; frame_tick is honoured in every state.

Reset
REQ-032 On reset: state IDLE, chart_addr 0, all slots free, lane_hit 0, busy 0, overflow 0, miss_count 0.
REQ-033 Reset mid-playback discards all notes immediately.
REQ-034 start pulse clears overflow.

Configuration
REQ-035 Macro NOTE_MISS_COUNT_EN defined: miss_count increments once per slot freed by REQ-028, saturating at 255, and clears on start.
REQ-036 If multiple slots free in one tick, miss_count adds their number, saturating.
REQ-037 Macro NOTE_MISS_COUNT_EN undefined: miss_count is constant 0 and no counter logic exists.

Verification
REQ-038 Reset, start, spawn_tick with chart_data=4'b0001: slot0 of lane0 at -50; after 25 frame_ticks pos=0; then x=170,y=0 gives lane_hit=4'b0001 one cycle later.
REQ-039 Five spawns of 4'b1000 with no frame_tick, SLOTS=4: four slots of lane3 active, overflow=1.
REQ-040 frame_tick coincident with FETCH: new note at -50 while existing notes move +2.
REQ-041 Note moved from pos 478 by one frame_tick: slot freed; miss_count=1 with NOTE_MISS_COUNT_EN defined, 0 without it.
REQ-042 reset asserted in DRAIN with 3 active notes: busy=0 and lane_hit=0 immediately; state IDLE.
REQ-043 CHART_DEPTH=2 playback: after second FETCH, busy stays high until last note exits, then IDLE; start accepted again.
